bus_source_sequencer: RTL and testbench
=======================================

Name: bus_source_sequencer

Overview:
- Multi-cycle control sequencer that drives the datapath's one-hot bus-source select vector, one microstep per clock.
- It sits directly upstream of the 32-to-5 bus-select encoder, which converts the vector to the bus mux select. An all-zero vector makes the encoder emit 31, meaning the bus is idle.
- Covers instruction fetch plus the execute bus transfers for a small op set, with a request/ready handshake to memory.

Parameters:
- SRC_W, 32, width of the one-hot source vector; must equal the encoder input width.
- REG_SEL_W, 4, width of the register index fields (R0..R15).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  begin an instruction; sampled only in IDLE.
- op  in  3  instruction class: 0 ALU rr, 1 ADDI, 2 LD, 3 ST, 4 MFHI, 5 MFLO, 6 IN, 7 illegal.
- ra  in  REG_SEL_W  store data register index.
- rb  in  REG_SEL_W  first operand / base register index.
- rc  in  REG_SEL_W  second operand register index.
- mem_ready  in  1  memory completion; honoured only in wait states.
- src_onehot  out  SRC_W  bus source select; at most one bit set.
- step  out  4  current state code, for debug and for the load-enable decoder.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the final step of an instruction.
- illegal  out  1  one-cycle pulse with done when op=7.
- mem_req  out  1  high in wait states.
- mem_we  out  1  high in the store wait state.

Behaviour:
- Source bit map:
  - bits 0-15: R0..R15
  - bit 16: HI, bit 17: LO, bit 18: Zhigh, bit 19: Zlow
  - bit 20: PC, bit 21: MDR, bit 22: InPort, bit 23: C sign-extended
  - bits 24-31 are never driven.
- Reset (clear=0, async): state=IDLE. src_onehot=0, step=0, busy=0, done=0, illegal=0, mem_req=0, mem_we=0. Reset mid-instruction aborts immediately; there is no resumption.
- Moore FSM: all outputs are decoded from the registered state. src_onehot is valid in the cycle the state is entered.
- start is accepted in IDLE only and is ignored while busy. op, ra, rb and rc are latched on acceptance; later input changes do not affect the running instruction.
- Fetch, common to all ops:
  - T0: PC.
  - T1: Zlow.
  - WF: src=0, mem_req=1; stays until mem_ready=1 is sampled, minimum one cycle.
  - T2: MDR.
- Execute:
  - ALU: T3 R[rb], T4 R[rc], T5 Zlow with done.
  - ADDI: T3 R[rb], T4 C, T5 Zlow with done.
  - LD:
    - T3 R[rb], T4 C, T5 Zlow.
    - WL: src=0, mem_req=1; stays until mem_ready.
    - T6: MDR with done.
  - ST:
    - T3 R[rb], T4 C, T5 Zlow, T6 R[ra].
    - WS: src=0, mem_req=1, mem_we=1; stays until mem_ready, then done is asserted in that exit cycle.
  - MFHI: T3 HI with done. MFLO: T3 LO with done. IN: T3 InPort with done.
  - Illegal (op=7): T3 with src=0, done=1, illegal=1.
- After any done cycle the next state is IDLE. A new start is accepted at the earliest in the IDLE cycle that follows. Back-to-back instructions therefore have exactly one IDLE cycle between them.
- mem_ready outside WF/WL/WS is ignored.
- step encoding:
  - IDLE=0, T0=1, T1=2, WF=3, T2=4, T3=5, T4=6, T5=7
  - WL=8, T6=9, WS=10
  - 11-15 unused; any unused state recovers to IDLE on the next edge.
- Invariant: src_onehot is zero or exactly one-hot at all times. No X values after reset.
- Latency with mem_ready held high, counted in cycles from start sampled to the done cycle inclusive:
  - ALU/ADDI: 7
  - LD: 9
  - ST: 9
  - MFHI/MFLO/IN/illegal: 5

Test Plan:
1. Reset mid-run: op=0, start, assert clear=0 while in T3 -> all outputs 0 within the same cycle, no edge needed. After release, start is required to restart.
2. ALU, mem_ready=1, rb=3, rc=7 -> src sequence 0x100000, 0x80000, 0, 0x200000, 0x8, 0x80, 0x80000. done pulses with the last value; busy covers 7 cycles.
3. LD with mem_ready low for 3 cycles in WL, rb=15 -> WL holds 3 cycles with src=0 and mem_req=1, mem_we=0. Then T6 src=0x200000 with done.
4. ST, ra=2 -> T6 src=0x4. In WS, mem_req=1 and mem_we=1 until mem_ready. done in the exit cycle, then IDLE.
5. start held high continuously with op=4 -> MFHI T3 src=0x10000 with done, IDLE one cycle, then re-accepted. Changing op mid-run has no effect.
6. op=7 -> fetch sequence completes, then one cycle src=0 with done=1 and illegal=1. A random mem_ready toggle outside wait states causes no state change.

Source files
------------

// File: rtl/bus_source_sequencer.sv
// bus_source_sequencer
//   Microstep sequencer for the datapath bus. Each state selects at most one
//   bus source through a one-hot vector that feeds the 32-to-5 bus-select
//   encoder. An all-zero vector means the bus is idle.
//   It covers instruction fetch, the execute transfers for ALU/ADDI/LD/ST/
//   MFHI/MFLO/IN, and an illegal-op trap. Memory is reached through a
//   request/ready handshake.
//
// Ports
//   clock       system clock, rising edge
//   clear       asynchronous active-low reset
//   start       begin an instruction (sampled only in IDLE)
//   op          instruction class (0 ALU,1 ADDI,2 LD,3 ST,4 MFHI,5 MFLO,6 IN,7 illegal)
//   ra/rb/rc    store-data / base / second-operand register indices
//   mem_ready   memory completion, honoured only in wait states
//   src_onehot  bus source select (zero or one-hot)
//   step        current state code
//   busy        high outside IDLE
//   done        pulse in the last step of an instruction
//   illegal     pulse together with done for op 7
//   mem_req     high in wait states
//   mem_we      high in the store wait state
module bus_source_sequencer #(
  parameter int SRC_W     = 32,
  parameter int REG_SEL_W = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [REG_SEL_W-1:0] ra,
  input  logic [REG_SEL_W-1:0] rb,
  input  logic [REG_SEL_W-1:0] rc,
  input  logic                 mem_ready,
  output logic [SRC_W-1:0]     src_onehot,
  output logic [3:0]           step,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic                 mem_req,
  output logic                 mem_we
);

  // State codes double as the external step value.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_WF   = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_WL   = 4'd8,
    S_T6   = 4'd9,
    S_WS   = 4'd10
  } state_t;

  localparam logic [2:0] OP_ALU  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_LD   = 3'd2;
  localparam logic [2:0] OP_ST   = 3'd3;
  localparam logic [2:0] OP_MFHI = 3'd4;
  localparam logic [2:0] OP_MFLO = 3'd5;
  localparam logic [2:0] OP_IN   = 3'd6;

  // Bus source bit positions; registers occupy 0..15.
  localparam logic [4:0] B_HI   = 5'd16;
  localparam logic [4:0] B_LO   = 5'd17;
  localparam logic [4:0] B_ZLOW = 5'd19;
  localparam logic [4:0] B_PC   = 5'd20;
  localparam logic [4:0] B_MDR  = 5'd21;
  localparam logic [4:0] B_IN   = 5'd22;
  localparam logic [4:0] B_C    = 5'd23;

  // Instruction fields captured at acceptance so later input activity
  // cannot disturb the running sequence.
  typedef struct packed {
    logic [2:0]           op;
    logic [REG_SEL_W-1:0] ra;
    logic [REG_SEL_W-1:0] rb;
    logic [REG_SEL_W-1:0] rc;
  } instr_t;

  state_t state, nxt;
  instr_t instr;

  function automatic logic [SRC_W-1:0] sel(input logic [4:0] idx);
    logic [SRC_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Ops that go through the address/ALU path in T3..T5.
  logic long_op;
  assign long_op = (instr.op == OP_ALU) || (instr.op == OP_ADDI) ||
                   (instr.op == OP_LD)  || (instr.op == OP_ST);

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= nxt;
  end

  // Instruction latch
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)                        instr <= '0;
    else if (state == S_IDLE && start) instr <= '{op: op, ra: ra, rb: rb, rc: rc};
  end

  // Next-state logic
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE: nxt = start ? S_T0 : S_IDLE;
      S_T0:   nxt = S_T1;
      S_T1:   nxt = S_WF;
      S_WF:   nxt = mem_ready ? S_T2 : S_WF;
      S_T2:   nxt = S_T3;
      S_T3:   nxt = long_op ? S_T4 : S_IDLE;
      S_T4:   nxt = S_T5;
      S_T5: begin
        if      (instr.op == OP_LD) nxt = S_WL;
        else if (instr.op == OP_ST) nxt = S_T6;
        else                        nxt = S_IDLE;
      end
      S_WL:   nxt = mem_ready ? S_T6 : S_WL;
      S_T6:   nxt = (instr.op == OP_ST) ? S_WS : S_IDLE;
      S_WS:   nxt = mem_ready ? S_IDLE : S_WS;
      default: nxt = S_IDLE;  // unused codes fall back to IDLE
    endcase
  end

  // Output decode. Everything follows the registered state; the store
  // wait is the one place done also looks at mem_ready, because the
  // instruction completes in the cycle the write is acknowledged.
  always_comb begin
    src_onehot = '0;
    done       = 1'b0;
    illegal    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    step       = state;
    busy       = (state != S_IDLE);
    case (state)
      S_T0: src_onehot = sel(B_PC);
      S_T1: src_onehot = sel(B_ZLOW);
      S_WF: mem_req    = 1'b1;
      S_T2: src_onehot = sel(B_MDR);
      S_T3: begin
        case (instr.op)
          OP_MFHI: begin src_onehot = sel(B_HI); done = 1'b1; end
          OP_MFLO: begin src_onehot = sel(B_LO); done = 1'b1; end
          OP_IN:   begin src_onehot = sel(B_IN); done = 1'b1; end
          3'd7:    begin done = 1'b1; illegal = 1'b1; end
          default: src_onehot = sel(5'(instr.rb));
        endcase
      end
      S_T4: src_onehot = (instr.op == OP_ALU) ? sel(5'(instr.rc)) : sel(B_C);
      S_T5: begin
        src_onehot = sel(B_ZLOW);
        done       = (instr.op == OP_ALU) || (instr.op == OP_ADDI);
      end
      S_WL: mem_req = 1'b1;
      S_T6: begin
        if (instr.op == OP_ST) src_onehot = sel(5'(instr.ra));
        else begin
          src_onehot = sel(B_MDR);
          done       = 1'b1;
        end
      end
      S_WS: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        done    = mem_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_source_sequencer.sv
module tb_bus_source_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = '0;
  logic [3:0]  ra = '0, rb = '0, rc = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] src_onehot;
  logic [3:0]  step;
  logic        busy, done, illegal, mem_req, mem_we;

  int passed = 0;
  int total  = 0;

  bus_source_sequencer #(.SRC_W(32), .REG_SEL_W(4)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op),
    .ra(ra), .rb(rb), .rc(rc), .mem_ready(mem_ready),
    .src_onehot(src_onehot), .step(step), .busy(busy), .done(done),
    .illegal(illegal), .mem_req(mem_req), .mem_we(mem_we)
  );

  always #5 clock = ~clock;

  // One expected cycle of an instruction, plus the mem_ready value the
  // bench drives during that cycle.
  typedef struct {
    logic [31:0] src;
    logic [3:0]  step;
    logic        req, we, dn, ill, rdy;
  } ent_t;

  ent_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic push(input logic [31:0] s, input logic [3:0] st, input logic req,
                      input logic we, input logic dn, input logic ill, input logic rdy);
    ent_t e;
    e.src = s; e.step = st; e.req = req; e.we = we; e.dn = dn; e.ill = ill; e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Memory wait of n stalled cycles followed by the acknowledging cycle.
  task automatic push_wait(input logic [3:0] st, input logic we, input int n, input logic dn_on_exit);
    for (int i = 0; i < n; i++) push(32'h0, st, 1'b1, we, 1'b0, 1'b0, 1'b0);
    push(32'h0, st, 1'b1, we, dn_on_exit, 1'b0, 1'b1);
  endtask

  // Reference: expected bus transfer list for one instruction.
  task automatic model(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input int wf_n, input int wl_n, input int ws_n);
    logic [31:0] pc, zl, mdr, cc;
    pc = 32'h1 << 20; zl = 32'h1 << 19; mdr = 32'h1 << 21; cc = 32'h1 << 23;
    exp_q.delete();
    push(pc, 4'd1, 0, 0, 0, 0, rnd_bit());
    push(zl, 4'd2, 0, 0, 0, 0, rnd_bit());
    push_wait(4'd3, 1'b0, wf_n, 1'b0);
    push(mdr, 4'd4, 0, 0, 0, 0, rnd_bit());
    case (o)
      3'd0, 3'd1: begin
        push(32'h1 << b, 4'd5, 0, 0, 0, 0, rnd_bit());
        push((o == 3'd0) ? (32'h1 << c) : cc, 4'd6, 0, 0, 0, 0, rnd_bit());
        push(zl, 4'd7, 0, 0, 1, 0, rnd_bit());
      end
      3'd2: begin
        push(32'h1 << b, 4'd5, 0, 0, 0, 0, rnd_bit());
        push(cc, 4'd6, 0, 0, 0, 0, rnd_bit());
        push(zl, 4'd7, 0, 0, 0, 0, rnd_bit());
        push_wait(4'd8, 1'b0, wl_n, 1'b0);
        push(mdr, 4'd9, 0, 0, 1, 0, rnd_bit());
      end
      3'd3: begin
        push(32'h1 << b, 4'd5, 0, 0, 0, 0, rnd_bit());
        push(cc, 4'd6, 0, 0, 0, 0, rnd_bit());
        push(zl, 4'd7, 0, 0, 0, 0, rnd_bit());
        push(32'h1 << a, 4'd9, 0, 0, 0, 0, rnd_bit());
        push_wait(4'd10, 1'b1, ws_n, 1'b1);
      end
      3'd4: push(32'h1 << 16, 4'd5, 0, 0, 1, 0, rnd_bit());
      3'd5: push(32'h1 << 17, 4'd5, 0, 0, 1, 0, rnd_bit());
      3'd6: push(32'h1 << 22, 4'd5, 0, 0, 1, 0, rnd_bit());
      default: push(32'h0, 4'd5, 0, 0, 1, 1, rnd_bit());
    endcase
  endtask

  // Entered one time unit after a rising edge with the DUT in IDLE.
  task automatic run_instr(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input int wf_n, input int wl_n,
                           input int ws_n, input bit hold);
    model(o, a, b, c, wf_n, wl_n, ws_n);
    mem_ready = rnd_bit();
    #1;
    check("idle_ctrl", {step, busy, done, illegal, mem_req, mem_we}, 64'h0);
    check("idle_src", src_onehot, 64'h0);
    start = 1'b1; op = o; ra = a; rb = b; rc = c;
    @(posedge clock); #1;
    foreach (exp_q[i]) begin
      // Scramble everything except the handshake to show it is ignored.
      start = hold ? 1'b1 : rnd_bit();
      op = 3'($urandom); ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      mem_ready = exp_q[i].rdy;
      #1;
      check($sformatf("src op%0d c%0d", o, i), src_onehot, exp_q[i].src);
      check($sformatf("ctrl op%0d c%0d", o, i),
            {step, busy, done, illegal, mem_req, mem_we},
            {exp_q[i].step, 1'b1, exp_q[i].dn, exp_q[i].ill, exp_q[i].req, exp_q[i].we});
      @(posedge clock); #1;
    end
  endtask

  initial begin
    // Reset state before any edge.
    #1;
    check("reset_all", {src_onehot, step, busy, done, illegal, mem_req, mem_we}, 64'h0);
    @(negedge clock); clear = 1'b1;
    @(posedge clock); #1;

    // Reset mid-run: ALU aborted in T3.
    model(3'd0, 4'd0, 4'd3, 4'd7, 0, 0, 0);
    start = 1'b1; op = 3'd0; rb = 4'd3; rc = 4'd7;
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      start = 1'b0;
      mem_ready = exp_q[i].rdy;
      #1;
      check($sformatf("pre_abort_src c%0d", i), src_onehot, exp_q[i].src);
      @(posedge clock); #1;
    end
    check("abort_t3_src", src_onehot, 64'h8);
    #2; clear = 1'b0; #1;
    check("abort_all", {src_onehot, step, busy, done, illegal, mem_req, mem_we}, 64'h0);
    @(posedge clock); #1;
    clear = 1'b1; start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check("post_abort_idle", {step, busy}, 64'h0);
    end

    // Directed instructions.
    run_instr(3'd0, 4'd9, 4'd3, 4'd7, 0, 0, 0, 1'b0);   // ALU
    run_instr(3'd2, 4'd0, 4'd15, 4'd1, 0, 3, 0, 1'b0);  // LD with 3 stalls
    run_instr(3'd3, 4'd2, 4'd5, 4'd0, 1, 0, 2, 1'b0);   // ST
    run_instr(3'd4, 4'd1, 4'd1, 4'd1, 0, 0, 0, 1'b1);   // MFHI, start held
    run_instr(3'd4, 4'd1, 4'd1, 4'd1, 0, 0, 0, 1'b1);   // re-accepted after one IDLE
    run_instr(3'd7, 4'd4, 4'd4, 4'd4, 2, 0, 0, 1'b0);   // illegal
    run_instr(3'd1, 4'd0, 4'd12, 4'd0, 0, 0, 0, 1'b0);  // ADDI
    run_instr(3'd5, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1'b0);   // MFLO
    run_instr(3'd6, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1'b0);   // IN

    // Random instructions with random stalls and idle gaps.
    for (int n = 0; n < 30; n++) begin
      int gap;
      run_instr(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        start = 1'b0; mem_ready = rnd_bit();
        @(posedge clock); #1;
        check("gap_idle", {step, busy, src_onehot}, 64'h0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
